// File: rtl/uart_cmd_sequencer.sv
// Two-byte UART command sequencer: takes a command and an operand byte,
// updates the LED register and answers with a two-byte response.
module uart_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  STATUS_CODE    = 8'h1F
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       rx_err,
    output logic       rx_en,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic [2:0] led,
    output logic       busy,
    output logic [7:0] err_count
);

    localparam int unsigned TW          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0]  CMD_STATUS  = 8'h01;
    localparam logic [7:0]  CMD_SET_LED = 8'h03;
    localparam logic [7:0]  RSP_ACK     = 8'hA5;
    localparam logic [7:0]  RSP_NAK     = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_OPERAND,
        ST_DECODE,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

    state_t          r_state, w_state;
    logic [7:0]      r_cmd, w_cmd;
    logic [7:0]      r_operand, w_operand;
    logic [TW-1:0]   r_timeout, w_timeout;
    logic [7:0]      r_resp0, w_resp0;
    logic [7:0]      r_resp1, w_resp1;
    logic            r_idx, w_idx;
    logic [2:0]      r_led, w_led;
    logic            r_rx_en, w_rx_en;
    logic            r_busy, w_busy;
    logic            r_tx_start, w_tx_start;
    logic [7:0]      r_tx_data, w_tx_data;
    logic [7:0]      r_err_count, w_err_count;
    logic            w_err_inc;

    // State and output registers; reset dominates every other input.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cmd       <= 8'h00;
            r_operand   <= 8'h00;
            r_timeout   <= '0;
            r_resp0     <= 8'h00;
            r_resp1     <= 8'h00;
            r_idx       <= 1'b0;
            r_led       <= 3'b000;
            r_rx_en     <= 1'b1;
            r_busy      <= 1'b0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_err_count <= 8'h00;
        end else begin
            r_state     <= w_state;
            r_cmd       <= w_cmd;
            r_operand   <= w_operand;
            r_timeout   <= w_timeout;
            r_resp0     <= w_resp0;
            r_resp1     <= w_resp1;
            r_idx       <= w_idx;
            r_led       <= w_led;
            r_rx_en     <= w_rx_en;
            r_busy      <= w_busy;
            r_tx_start  <= w_tx_start;
            r_tx_data   <= w_tx_data;
            r_err_count <= w_err_count;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state     = r_state;
        w_cmd       = r_cmd;
        w_operand   = r_operand;
        w_timeout   = r_timeout;
        w_resp0     = r_resp0;
        w_resp1     = r_resp1;
        w_idx       = r_idx;
        w_led       = r_led;
        w_tx_start  = 1'b0;
        w_tx_data   = r_tx_data;
        w_err_inc   = 1'b0;
        w_err_count = r_err_count;

        case (r_state)
            ST_IDLE: begin
                if (rx_err) begin
                    w_err_inc = 1'b1;
                end else if (rx_done) begin
                    w_cmd     = rx_data;
                    w_timeout = '0;
                    w_state   = ST_GET_OPERAND;
                end
            end
            ST_GET_OPERAND: begin
                // A byte arriving on the last allowed cycle still beats the timeout.
                if (rx_err) begin
                    w_err_inc = 1'b1;
                    w_state   = ST_IDLE;
                end else if (rx_done) begin
                    w_operand = rx_data;
                    w_state   = ST_DECODE;
                end else if (r_timeout == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_err_inc = 1'b1;
                    w_state   = ST_IDLE;
                end else begin
                    w_timeout = r_timeout + TW'(1);
                end
            end
            ST_DECODE: begin
                w_idx   = 1'b0;
                w_state = ST_SEND;
                case (r_cmd)
                    CMD_STATUS: begin
                        w_resp0 = STATUS_CODE;
                        w_resp1 = {5'b00000, r_led};
                    end
                    CMD_SET_LED: begin
                        w_led   = r_operand[2:0];
                        w_resp0 = RSP_ACK;
                        w_resp1 = r_operand;
                    end
                    default: begin
                        w_resp0 = RSP_NAK;
                        w_resp1 = r_cmd;
                    end
                endcase
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    w_tx_start = 1'b1;
                    w_tx_data  = r_idx ? r_resp1 : r_resp0;
                    w_state    = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                if (tx_done) begin
                    if (!r_idx) begin
                        w_idx   = 1'b1;
                        w_state = ST_SEND;
                    end else begin
                        w_state = ST_IDLE;
                    end
                end
            end
            default: w_state = ST_IDLE;
        endcase

        if (w_err_inc && (r_err_count != 8'hFF)) begin
            w_err_count = r_err_count + 8'd1;
        end

        w_rx_en = (w_state == ST_IDLE) || (w_state == ST_GET_OPERAND);
        w_busy  = !w_rx_en;
    end

    assign rx_en     = r_rx_en;
    assign busy      = r_busy;
    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign led       = r_led;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer with hand-computed expected responses.
module tb_uart_cmd_sequencer;

    localparam int unsigned TO = 20;
    localparam logic [7:0]  SC = 8'h1F;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_err;
    logic       rx_en;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic [2:0] led;
    logic       busy;
    logic [7:0] err_count;

    int n_cmp    = 0;
    int n_bad    = 0;
    int n_starts = 0;

    always #5 clock = ~clock;

    uart_cmd_sequencer #(
        .TIMEOUT_CYCLES (TO),
        .STATUS_CODE    (SC)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_err    (rx_err),
        .rx_en     (rx_en),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .led       (led),
        .busy      (busy),
        .err_count (err_count)
    );

    // Count tx_start pulses away from the active edge.
    always @(negedge clock) begin
        if (tx_start === 1'b1) n_starts <= n_starts + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick(1);
        rx_done = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int budget, output int cyc);
        cyc = 0;
        while ((tx_start !== 1'b1) && (cyc < budget)) begin
            tick(1);
            cyc++;
        end
        check({tag, "_start_seen"}, 32'(tx_start), 32'd1);
    endtask

    // Transmitter stand-in: busy for a few cycles, then a tx_done pulse.
    task automatic serve_tx(input string tag);
        tx_busy = 1'b1;
        tick(1);
        check({tag, "_start_one_cycle"}, 32'(tx_start), 32'd0);
        tick(2);
        tx_busy = 1'b0;
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                               input int first_lat);
        int cyc;
        int s0;
        s0 = n_starts;
        wait_start({tag, "_b0"}, 20, cyc);
        check({tag, "_b0_latency"}, 32'(cyc), 32'(first_lat));
        check({tag, "_b0_data"}, 32'(tx_data), 32'(b0));
        check({tag, "_busy_b0"}, 32'(busy), 32'd1);
        serve_tx({tag, "_b0"});
        check({tag, "_busy_between"}, 32'(busy), 32'd1);
        wait_start({tag, "_b1"}, 20, cyc);
        check({tag, "_b1_latency"}, 32'(cyc), 32'd1);
        check({tag, "_b1_data"}, 32'(tx_data), 32'(b1));
        serve_tx({tag, "_b1"});
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_rx_en_done"}, 32'(rx_en), 32'd1);
        check({tag, "_start_count"}, 32'(n_starts - s0), 32'd2);
    endtask

    initial begin
        int s0;
        reset_n = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        rx_err  = 1'b0;
        tx_busy = 1'b0;
        tx_done = 1'b0;

        // Reset values
        tick(2);
        check("rst_led", 32'(led), 32'd0);
        check("rst_rx_en", 32'(rx_en), 32'd1);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        reset_n = 1'b1;
        tick(1);

        // tx_done outside WAIT_TX has no effect
        s0 = n_starts;
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        tick(3);
        check("stray_done_starts", 32'(n_starts - s0), 32'd0);
        check("stray_done_busy", 32'(busy), 32'd0);

        // Set LED: 03, 05
        put_byte(8'h03);
        check("setled_getop_busy", 32'(busy), 32'd0);
        check("setled_getop_rx_en", 32'(rx_en), 32'd1);
        put_byte(8'h05);
        check("setled_decode_busy", 32'(busy), 32'd1);
        check("setled_decode_rx_en", 32'(rx_en), 32'd0);
        expect_resp("setled", 8'hA5, 8'h05, 2);
        check("setled_led", 32'(led), 32'd5);

        // Status: 01, 00
        put_byte(8'h01);
        put_byte(8'h00);
        expect_resp("status", SC, 8'h05, 2);
        check("status_led", 32'(led), 32'd5);

        // Timeout after command byte
        s0 = n_starts;
        put_byte(8'h03);
        tick(TO - 1);
        check("to_last_cycle_err", 32'(err_count), 32'd0);
        check("to_last_cycle_rx_en", 32'(rx_en), 32'd1);
        tick(1);
        check("to_err", 32'(err_count), 32'd1);
        check("to_rx_en", 32'(rx_en), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        tick(5);
        check("to_no_start", 32'(n_starts - s0), 32'd0);
        check("to_led", 32'(led), 32'd5);

        // Operand on the last allowed cycle wins over the timeout
        put_byte(8'h03);
        tick(TO - 1);
        put_byte(8'h06);
        expect_resp("to_edge", 8'hA5, 8'h06, 2);
        check("to_edge_led", 32'(led), 32'd6);
        check("to_edge_err", 32'(err_count), 32'd1);

        // Unknown command, transmitter held busy in SEND; rx ignored while answering
        put_byte(8'h7C);
        put_byte(8'h00);
        s0 = n_starts;
        tx_busy = 1'b1;
        tick(4);
        rx_data = 8'h03;
        rx_done = 1'b1;
        rx_err  = 1'b1;
        tick(1);
        rx_done = 1'b0;
        rx_err  = 1'b0;
        tick(7);
        check("bad_held_no_start", 32'(n_starts - s0), 32'd0);
        check("bad_held_busy", 32'(busy), 32'd1);
        check("bad_ignored_err", 32'(err_count), 32'd1);
        tx_busy = 1'b0;
        expect_resp("bad", 8'hEE, 8'h7C, 1);
        check("bad_led", 32'(led), 32'd6);
        check("bad_err", 32'(err_count), 32'd1);

        // Receiver errors discard partial commands
        put_byte(8'h03);
        rx_err = 1'b1;
        tick(1);
        rx_err = 1'b0;
        check("rxerr_between_err", 32'(err_count), 32'd2);
        check("rxerr_between_busy", 32'(busy), 32'd0);
        rx_data = 8'h03;
        rx_done = 1'b1;
        rx_err  = 1'b1;
        tick(1);
        rx_done = 1'b0;
        rx_err  = 1'b0;
        check("rxerr_idle_both_err", 32'(err_count), 32'd3);
        put_byte(8'h03);
        rx_data = 8'h07;
        rx_done = 1'b1;
        rx_err  = 1'b1;
        tick(1);
        rx_done = 1'b0;
        rx_err  = 1'b0;
        check("rxerr_getop_both_err", 32'(err_count), 32'd4);
        s0 = n_starts;
        tick(5);
        check("rxerr_no_start", 32'(n_starts - s0), 32'd0);
        check("rxerr_led", 32'(led), 32'd6);
        put_byte(8'h01);
        put_byte(8'h00);
        expect_resp("after_rxerr", SC, 8'h06, 2);

        // Saturation
        rx_err = 1'b1;
        tick(300);
        rx_err = 1'b0;
        check("err_saturate", 32'(err_count), 32'hFF);
        tick(1);
        check("err_hold", 32'(err_count), 32'hFF);

        // Reset after first tx_done abandons the response
        put_byte(8'h03);
        put_byte(8'h02);
        begin
            int cyc;
            wait_start("rstmid", 20, cyc);
        end
        check("rstmid_b0_data", 32'(tx_data), 32'hA5);
        serve_tx("rstmid");
        s0 = n_starts;
        reset_n = 1'b0;
        tick(1);
        check("rstmid_led", 32'(led), 32'd0);
        check("rstmid_rx_en", 32'(rx_en), 32'd1);
        check("rstmid_tx_start", 32'(tx_start), 32'd0);
        check("rstmid_tx_data", 32'(tx_data), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_err", 32'(err_count), 32'd0);
        reset_n = 1'b1;
        tick(10);
        check("rstmid_no_start", 32'(n_starts - s0), 32'd0);

        // Fresh command after reset
        put_byte(8'h01);
        put_byte(8'h00);
        expect_resp("post_rst", SC, 8'h00, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
